// File: rtl/handle_mark.sv
// Marks called numbers on a 5x5 bingo board, then rescans all 12 lines
// to recount completed lines and raise bingo once WIN_LINES are reached.
module handle_mark #(
    parameter int WIN_LINES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         interboard_rst,
    input  logic         clear,
    input  logic [124:0] map,
    input  logic [124:0] num_to_pos,
    input  logic         call_valid,
    input  logic [4:0]   call_number,
    output logic         call_ready,
    output logic         mark_done,
    output logic         rejected,
    output logic [24:0]  marked,
    output logic [3:0]   line_count,
    output logic         bingo
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WIN_LINES_W = 4'(WIN_LINES);
    localparam logic [3:0] LAST_LINE   = 4'd11;

    state_t      state_q, state_d;
    logic [4:0]  num_q, num_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  acc_q, acc_d;
    logic [24:0] marked_q, marked_d;
    logic [3:0]  line_count_q, line_count_d;
    logic        mark_done_q, mark_done_d;
    logic        rejected_q, rejected_d;
    logic        call_ready_q, call_ready_d;

    logic        num_ok_s;
    logic [6:0]  pos_base_s;
    logic [4:0]  pos_s;
    logic        pos_ok_s;
    logic [6:0]  map_base_s;
    logic [4:0]  map_field_s;
    logic [24:0] cell_s;
    logic        dup_s;
    logic        lookup_ok_s;
    logic [24:0] line_mask_s;
    logic        line_full_s;

    // Cell set of scan line idx: rows 0-4, columns 5-9, diagonals 10-11.
    function automatic logic [24:0] line_mask(input logic [3:0] idx);
        logic [24:0] m;
        case (idx)
            4'd0:    m = 25'h000001F;
            4'd1:    m = 25'h00003E0;
            4'd2:    m = 25'h0007C00;
            4'd3:    m = 25'h00F8000;
            4'd4:    m = 25'h1F00000;
            4'd5:    m = 25'h0108421;
            4'd6:    m = 25'h0210842;
            4'd7:    m = 25'h0421084;
            4'd8:    m = 25'h0842108;
            4'd9:    m = 25'h1084210;
            4'd10:   m = 25'h1041041;
            4'd11:   m = 25'h0111110;
            default: m = 25'h0000000;
        endcase
        return m;
    endfunction

    // Lookup datapath: indices are forced in range so part-selects never run off the buses.
    always_comb begin
        num_ok_s    = (num_q != 5'd0) && (num_q <= 5'd25);
        pos_base_s  = num_ok_s ? (({2'b00, num_q} - 7'd1) * 7'd5) : 7'd0;
        pos_s       = num_to_pos[pos_base_s +: 5];
        pos_ok_s    = (pos_s <= 5'd24);
        map_base_s  = pos_ok_s ? ({2'b00, pos_s} * 7'd5) : 7'd0;
        map_field_s = map[map_base_s +: 5];
        cell_s      = pos_ok_s ? (25'd1 << pos_s) : 25'd0;
        dup_s       = |(marked_q & cell_s);
        lookup_ok_s = pos_ok_s && (map_field_s == num_q) && !dup_s;
        line_mask_s = line_mask(idx_q);
        line_full_s = ((marked_q & line_mask_s) == line_mask_s);
    end

    // Next-state and next-output logic for the call sequencer.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        marked_d     = marked_q;
        line_count_d = line_count_q;
        mark_done_d  = 1'b0;
        rejected_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (call_valid) begin
                    num_d = call_number;
                    if ((call_number == 5'd0) || (call_number > 5'd25)) begin
                        state_d     = S_DONE;
                        mark_done_d = 1'b1;
                        rejected_d  = 1'b1;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (lookup_ok_s) begin
                    marked_d = marked_q | cell_s;
                    idx_d    = 4'd0;
                    acc_d    = 4'd0;
                    state_d  = S_CHECK;
                end else begin
                    state_d     = S_DONE;
                    mark_done_d = 1'b1;
                    rejected_d  = 1'b1;
                end
            end
            S_CHECK: begin
                // Full recount each call; the last line folds straight into line_count.
                if (idx_q == LAST_LINE) begin
                    line_count_d = acc_q + {3'b000, line_full_s};
                    state_d      = S_DONE;
                    mark_done_d  = 1'b1;
                end else begin
                    acc_d = acc_q + {3'b000, line_full_s};
                    idx_d = idx_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            state_d      = S_IDLE;
            num_d        = 5'd0;
            idx_d        = 4'd0;
            acc_d        = 4'd0;
            marked_d     = 25'd0;
            line_count_d = 4'd0;
            mark_done_d  = 1'b0;
            rejected_d   = 1'b0;
        end else begin
            state_d = state_d;
        end

        call_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; either board reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            state_q      <= S_IDLE;
            num_q        <= 5'd0;
            idx_q        <= 4'd0;
            acc_q        <= 4'd0;
            marked_q     <= 25'd0;
            line_count_q <= 4'd0;
            mark_done_q  <= 1'b0;
            rejected_q   <= 1'b0;
            call_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            marked_q     <= marked_d;
            line_count_q <= line_count_d;
            mark_done_q  <= mark_done_d;
            rejected_q   <= rejected_d;
            call_ready_q <= call_ready_d;
        end
    end

    assign call_ready = call_ready_q;
    assign mark_done  = mark_done_q;
    assign rejected   = rejected_q;
    assign marked     = marked_q;
    assign line_count = line_count_q;
    assign bingo      = (line_count_q >= WIN_LINES_W);

endmodule

// File: tb/tb_handle_mark.sv
// Directed + randomized bench for handle_mark against a board-level model
// that tracks marks as an array and counts lines by geometry.
module tb_handle_mark;

    logic         clk;
    logic         rst;
    logic         interboard_rst;
    logic         clear;
    logic [124:0] map;
    logic [124:0] num_to_pos;
    logic         call_valid;
    logic [4:0]   call_number;
    logic         call_ready;
    logic         mark_done;
    logic         rejected;
    logic [24:0]  marked;
    logic [3:0]   line_count;
    logic         bingo;

    int n_checks = 0;
    int n_fail   = 0;

    int mp[25];
    int n2p[26];
    bit mk[25];

    handle_mark #(.WIN_LINES(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .clear          (clear),
        .map            (map),
        .num_to_pos     (num_to_pos),
        .call_valid     (call_valid),
        .call_number    (call_number),
        .call_ready     (call_ready),
        .mark_done      (mark_done),
        .rejected       (rejected),
        .marked         (marked),
        .line_count     (line_count),
        .bingo          (bingo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_lines();
        int n;
        bit all;
        n = 0;
        for (int r = 0; r < 5; r++) begin
            all = 1'b1;
            for (int k = 0; k < 5; k++) if (!mk[5*r+k]) all = 1'b0;
            if (all) n++;
        end
        for (int c = 0; c < 5; c++) begin
            all = 1'b1;
            for (int k = 0; k < 5; k++) if (!mk[c+5*k]) all = 1'b0;
            if (all) n++;
        end
        all = 1'b1;
        for (int k = 0; k < 5; k++) if (!mk[6*k]) all = 1'b0;
        if (all) n++;
        all = 1'b1;
        for (int k = 0; k < 5; k++) if (!mk[4+4*k]) all = 1'b0;
        if (all) n++;
        return n;
    endfunction

    function automatic logic [24:0] model_marked();
        logic [24:0] v;
        for (int p = 0; p < 25; p++) v[p] = mk[p];
        return v;
    endfunction

    task automatic identity_board();
        for (int p = 0; p < 25; p++) mp[p] = p + 1;
        n2p[0] = 0;
        for (int n = 1; n <= 25; n++) n2p[n] = n - 1;
    endtask

    task automatic apply_board();
        for (int p = 0; p < 25; p++) map[5*p +: 5] = 5'(mp[p]);
        for (int n = 1; n <= 25; n++) num_to_pos[5*n-5 +: 5] = 5'(n2p[n]);
    endtask

    task automatic model_clear();
        for (int p = 0; p < 25; p++) mk[p] = 1'b0;
    endtask

    // Issue one call from a negedge, wait for mark_done and check the outcome.
    task automatic do_call(input int num);
        int  exp_lat;
        bit  exp_rej;
        int  pos;
        int  cyc;
        bit  done;
        pos = 0;
        if (num < 1 || num > 25) begin
            exp_lat = 1; exp_rej = 1'b1;
        end else begin
            pos = n2p[num];
            if (pos > 24 || mp[pos] != num || mk[pos]) begin
                exp_lat = 2; exp_rej = 1'b1;
            end else begin
                exp_lat = 14; exp_rej = 1'b0;
            end
        end
        chk("ready_before_call", 32'(call_ready), 32'd1);
        call_valid  = 1'b1;
        call_number = 5'(num);
        @(posedge clk);
        #1 call_valid = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mark_done === 1'b1) done = 1'b1;
            else chk("ready_low_busy", 32'(call_ready), 32'd0);
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("rejected", 32'(rejected), 32'(exp_rej));
        if (!exp_rej) mk[pos] = 1'b1;
        chk("marked", 32'(marked), 32'(model_marked()));
        chk("line_count", 32'(line_count), 32'(model_lines()));
        chk("bingo", 32'(bingo), 32'(model_lines() >= 3));
        @(negedge clk);
        chk("rejected_after", 32'(rejected), 32'd0);
        chk("done_after", 32'(mark_done), 32'd0);
        chk("ready_after", 32'(call_ready), 32'd1);
    endtask

    // Start a call, abort it mid-scan with clear or interboard_rst while a new call is offered.
    task automatic abort_test(input bit use_ibr, input int start_num, input int next_num);
        call_valid  = 1'b1;
        call_number = 5'(start_num);
        @(posedge clk);
        #1 call_valid = 1'b0;
        repeat (4) @(negedge clk);
        if (use_ibr) interboard_rst = 1'b1;
        else clear = 1'b1;
        call_valid  = 1'b1;
        call_number = 5'(next_num);
        @(posedge clk);
        #1;
        clear = 1'b0;
        interboard_rst = 1'b0;
        model_clear();
        @(negedge clk);
        chk("abort_ready", 32'(call_ready), 32'd1);
        chk("abort_marked", 32'(marked), 32'd0);
        chk("abort_lines", 32'(line_count), 32'd0);
        chk("abort_done", 32'(mark_done), 32'd0);
        chk("abort_rej", 32'(rejected), 32'd0);
        do_call(next_num);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        model_clear();
        @(negedge clk);
        chk("clear_marked", 32'(marked), 32'd0);
        chk("clear_lines", 32'(line_count), 32'd0);
    endtask

    initial begin
        int perm[25];
        int j;
        int t;
        rst            = 1'b1;
        interboard_rst = 1'b0;
        clear          = 1'b0;
        call_valid     = 1'b0;
        call_number    = 5'd0;
        map            = 125'd0;
        num_to_pos     = 125'd0;
        identity_board();
        apply_board();
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(call_ready), 32'd1);
        chk("rst_marked", 32'(marked), 32'd0);
        chk("rst_lines", 32'(line_count), 32'd0);
        chk("rst_bingo", 32'(bingo), 32'd0);
        chk("rst_done", 32'(mark_done), 32'd0);
        chk("rst_rej", 32'(rejected), 32'd0);

        for (int n = 1; n <= 5; n++) do_call(n);
        chk("row0_marked", 32'(marked), 32'h000001F);
        chk("row0_lines", 32'(line_count), 32'd1);
        chk("row0_bingo", 32'(bingo), 32'd0);

        do_call(6); do_call(11); do_call(16); do_call(21);
        chk("col0_lines", 32'(line_count), 32'd2);
        do_call(7); do_call(13); do_call(19); do_call(25);
        chk("diag_lines", 32'(line_count), 32'd3);
        chk("diag_bingo", 32'(bingo), 32'd1);

        do_call(3); do_call(3);
        do_call(0); do_call(26);

        abort_test(1'b0, 20, 9);
        abort_test(1'b1, 20, 9);

        do_clear();
        mp[4] = 9;
        apply_board();
        do_call(5);
        chk("corrupt_cell4", 32'(marked[4]), 32'd0);
        mp[4] = 5;
        apply_board();

        do_clear();
        for (int i = 0; i < 25; i++) perm[i] = i + 1;
        for (int i = 24; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(3, 0) == 0) do_call($urandom_range(31, 0));
            do_call(perm[i]);
        end
        chk("final_lines", 32'(line_count), 32'd12);
        chk("final_bingo", 32'(bingo), 32'd1);
        chk("final_marked", 32'(marked), 32'h1FFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
